// File: rtl/pixel_out_streamer.sv
// Purpose : egress FIFO for the valid-only pixel stream, emitted on ready/valid with SOF/EOL/EOF markers.
// Latency : a pixel pushed on edge N is presented (first-word-fall-through) from edge N; no same-cycle bypass.
// Backpres: none upstream; a push into a full FIFO with no pop is dropped, flagged sticky and counted.
module pixel_out_streamer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic [7:0]                         pixel_in,
  input  logic                               pixel_in_valid,
  output logic [7:0]                         pixel_out,
  output logic                               pixel_out_valid,
  input  logic                               pixel_out_ready,
  output logic                               pixel_out_sof,
  output logic                               pixel_out_eol,
  output logic                               pixel_out_eof,
  output logic                               frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  output logic [15:0]                        drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             frame_done_q;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;
  state_t           state_q;

  logic head_vld, full, pop, wr_en, drop, col_last, row_last;

  assign head_vld = (level_q != '0);
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop      = head_vld & pixel_out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign wr_en    = pixel_in_valid & (~full | pop);
  assign drop     = pixel_in_valid & full & ~pop;
  assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));

  // Head data is forced to zero when empty so reset clears it without touching the RAM.
  assign pixel_out       = head_vld ? mem_q[rd_ptr_q] : 8'h00;
  assign pixel_out_valid = head_vld;
  assign pixel_out_sof   = head_vld & (col_q == '0) & (row_q == '0);
  assign pixel_out_eol   = head_vld & col_last;
  assign pixel_out_eof   = head_vld & col_last & row_last;
  assign frame_done      = frame_done_q;
  assign fifo_level      = level_q;
  assign overflow        = overflow_q;
  assign drop_count      = drop_cnt_q;

  // Occupancy next state: unchanged on push+pop, otherwise up or down by one.
  always_comb begin
    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Pixel storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= pixel_in;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Frame position of the head pixel; advances on delivered pixels only.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop & col_last & row_last;
      if (pop) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'h0001;
    end
  end

  // Activity tracker: idle while empty, streaming while anything is buffered.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (pixel_in_valid) state_q <= S_STREAM;
        S_STREAM: if (level_d == '0)  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pixel_out_streamer.md
Name: pixel_out_streamer

Overview:
- Egress end of the pixel pipeline. Accepts the valid-only 8-bit pixel stream produced by the edge stages, such as gradient magnitude or the final edge map. Buffers it in a small FIFO and emits it on a ready/valid interface with frame markers: start of frame, end of line, end of frame.
- It is the transmitter counterpart of the pixel_in/pixel_in_valid ingress used by pixel_loader. The upstream stages cannot stall, so overflow is detected and counted, never back-pressured.

Parameters:
- IMG_WIDTH, 512, pixels per output line.
- IMG_HEIGHT, 512, lines per output frame.
- FIFO_DEPTH, 16, buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- pixel_in  in  8  upstream pixel.
- pixel_in_valid  in  1  upstream pixel is present this cycle (no stall path).
- pixel_out  out  8  downstream pixel (FIFO head).
- pixel_out_valid  out  1  pixel_out holds a valid pixel.
- pixel_out_ready  in  1  downstream accepts this cycle.
- pixel_out_sof  out  1  head pixel is frame pixel (0,0); qualified by pixel_out_valid.
- pixel_out_eol  out  1  head pixel is the last column of its line.
- pixel_out_eof  out  1  head pixel is the last pixel of the frame.
- frame_done  out  1  one-cycle pulse after the eof pixel transfers.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky; a pixel was dropped.
- drop_count  out  16  dropped pixels, saturating at 16'hFFFF.

Behaviour:
- Reset (rstN low, asynchronous): all outputs 0, FIFO empty, pointers 0, column/row counters 0, overflow and drop_count 0. This applies mid-frame and mid-transfer with no exception. Buffered pixels are discarded.
- Terms:
  - Push = pixel_in_valid high.
  - Pop = pixel_out_valid and pixel_out_ready both high at a rising edge.
- Storage and output:
  - Push writes pixel_in at the write pointer on the clock edge.
  - pixel_out_valid = (level != 0), registered.
  - The FIFO is first-word-fall-through: the head is presented on pixel_out without a read request.
  - Latency: a pixel pushed at edge N into an empty FIFO is valid from edge N to edge N+1. There is no same-cycle bypass.
- pixel_out and markers hold stable while pixel_out_valid is high and pixel_out_ready is low.
- Simultaneous push and pop:
  - Level is unchanged, the head advances, and the new pixel is stored.
  - This holds when full: the pop frees a slot, so no drop occurs.
- Push while full with no pop: the pixel is discarded. overflow goes high from the next edge and stays high until reset. drop_count increments, saturating.
- Pop while empty cannot occur, because valid is low.
- Pointers wrap modulo FIFO_DEPTH. Level ranges from 0 to FIFO_DEPTH.
- Frame position:
  - col counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) describe the head pixel.
  - Both advance only on pop. col wraps to 0 and increments row. After the last pixel both wrap to 0.
  - Markers are combinational from the counters ANDed with pixel_out_valid:
    - sof = col==0 && row==0.
    - eol = col==IMG_WIDTH-1.
    - eof = eol && row==IMG_HEIGHT-1.
- frame_done: registered, high for exactly the one cycle after the edge on which the eof pixel popped. Back-to-back frames are allowed, and sof is asserted on the following head pixel.
- Dropped pixels do not advance the counters, so framing is defined on delivered pixels only. Overflow is the indication that framing is corrupt.
- Control state machine, encoded via the counters and level:
  - IDLE (level 0) goes to STREAM on push.
  - STREAM goes back to IDLE when level returns to 0.
  - The state affects no outputs beyond those listed above.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with ready=1.
  - pixel_out is 0x11/0x22/0x33 on cycles 1/2/3 after each push; sof high with 0x11 only.
  - fifo_level never exceeds 1.
- ready=0 and push 16 pixels 0x00..0x0F, then a 17th pixel 0xAA.
  - fifo_level=16.
  - overflow=1 and drop_count=1 from the next edge.
  - Raising ready drains 0x00..0x0F in order; 0xAA is never output.
- FIFO full, ready=1, push 0x55 in the same cycle.
  - No drop: overflow stays 0 and level stays 16.
  - 0x55 emerges after the 16 queued pixels.
- IMG_WIDTH=4, IMG_HEIGHT=2, stream 8 pixels with ready=1.
  - eol on pixels 3 and 7; eof on pixel 7 only.
  - frame_done pulses once, the cycle after pixel 7 pops.
  - A 9th pixel shows sof=1.
- Random ready (50%) with continuous push at 40% for 3 frames of 4x2.
  - Output sequence equals input sequence.
  - Data and markers hold stable while stalled; overflow=0.
- Fill the FIFO to 5, then assert rstN=0 between clock edges.
  - All outputs go to 0 immediately without waiting for an edge.
  - After release, the first new push is marked sof.
